// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_port_arbiter: shares one single-port BRAM between fetch and data,    |
// | with per-side stalls and a starvation guard for fetch.  Revision: 1.0    |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_AW     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [DATA_W-1:0] o_if_rdata,
  output logic              o_if_valid,
  output logic              o_if_stall,
  input  logic              i_d_req,
  input  logic              i_d_we,
  input  logic [3:0]        i_d_be,
  input  logic [ADDR_W-1:0] i_d_addr,
  input  logic [DATA_W-1:0] i_d_wdata,
  output logic [DATA_W-1:0] o_d_rdata,
  output logic              o_d_valid,
  output logic              o_d_stall,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int              CNT_W        = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] C_STARVE_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_starve_cnt;
  logic [CNT_W-1:0]   w_starve_nxt;
  logic               w_grant_if;
  logic               w_grant_d;
  logic [MEM_AW-1:0]  r_last_addr;
  logic [DATA_W-1:0]  r_last_wdata;

  // Only the word-address bits reach the BRAM; byte offset and high bits are dropped.
  logic [2*(ADDR_W-MEM_AW)-1:0] w_unused_addr_bits;
  assign w_unused_addr_bits = {i_if_addr[ADDR_W-1:MEM_AW+2], i_if_addr[1:0],
                               i_d_addr[ADDR_W-1:MEM_AW+2],  i_d_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_last_addr  <= '0;
      r_last_wdata <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
      if (o_mem_en) begin
        r_last_addr  <= o_mem_addr;
        r_last_wdata <= o_mem_wdata;
      end
    end
  end

  always_comb begin
    w_grant_if   = 1'b0;
    w_grant_d    = 1'b0;
    w_state_nxt  = S_IDLE;
    w_starve_nxt = '0;
    o_mem_en     = 1'b0;
    o_mem_we     = 4'b0000;
    o_mem_addr   = r_last_addr;
    o_mem_wdata  = r_last_wdata;

    // Data wins conflicts until fetch has waited through STARVE_MAX data grants.
    if (i_if_req && (!i_d_req || r_starve_cnt == C_STARVE_MAX)) begin
      w_grant_if = 1'b1;
    end else if (i_d_req) begin
      w_grant_d = 1'b1;
    end

    if (w_grant_if) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_if_addr[MEM_AW+1:2];
      w_state_nxt = S_FETCH;
    end else if (w_grant_d) begin
      o_mem_en    = 1'b1;
      o_mem_addr  = i_d_addr[MEM_AW+1:2];
      o_mem_wdata = i_d_wdata;
      o_mem_we    = i_d_we ? i_d_be : 4'b0000;
      w_state_nxt = i_d_we ? S_STORE : S_LOAD;
    end

    if (i_if_req && w_grant_d) begin
      w_starve_nxt = (r_starve_cnt == C_STARVE_MAX) ? r_starve_cnt
                                                    : r_starve_cnt + 1'b1;
    end
  end

  assign o_if_stall = i_if_req & ~w_grant_if;
  assign o_d_stall  = i_d_req  & ~w_grant_d;
  assign o_if_valid = (r_state == S_FETCH);
  assign o_d_valid  = (r_state == S_LOAD);
  assign o_if_rdata = i_mem_rdata;
  assign o_d_rdata  = i_mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// tb_mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model with its own shadow memory image.
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_AW(12), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .reset(reset),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata),
    .o_if_valid(if_valid), .o_if_stall(if_stall),
    .i_d_req(d_req), .i_d_we(d_we), .i_d_be(d_be), .i_d_addr(d_addr),
    .i_d_wdata(d_wdata), .o_d_rdata(d_rdata), .o_d_valid(d_valid),
    .o_d_stall(d_stall),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4)  return 32'h00A00093;
    if (i == 32) return 32'h11223344;
    return (i * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // BRAM: registered read, byte-lane writes.
  logic [31:0] ram [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = init_word(i);
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        mem_rdata <= ram[mem_addr];
        for (int b = 0; b < 4; b++)
          if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_mem [0:4095];
  int          m_starve;
  logic        m_if_valid;
  logic        m_d_valid;
  logic [31:0] m_rdata;

  task automatic step(input logic rst_n, input logic ifr, input logic [31:0] ifa,
                      input logic dr, input logic dwe, input logic [3:0] dbe,
                      input logic [31:0] da, input logic [31:0] dwd);
    logic g_if, g_d;
    int   wi, wd;
    @(negedge clk);
    reset = rst_n; if_req = ifr; if_addr = ifa;
    d_req = dr; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    check("if_valid", {31'b0, if_valid}, {31'b0, m_if_valid});
    check("d_valid",  {31'b0, d_valid},  {31'b0, m_d_valid});
    if (m_if_valid) check("if_rdata", if_rdata, m_rdata);
    if (m_d_valid)  check("d_rdata",  d_rdata,  m_rdata);

    g_if = ifr && (!dr || m_starve >= STARVE_MAX);
    g_d  = dr && !g_if;
    wi   = int'(ifa[13:2]);
    wd   = int'(da[13:2]);
    check("if_stall", {31'b0, if_stall}, {31'b0, ifr && !g_if});
    check("d_stall",  {31'b0, d_stall},  {31'b0, dr && !g_d});
    check("mem_en",   {31'b0, mem_en},   {31'b0, g_if || g_d});
    check("mem_we",   {28'b0, mem_we},   {28'b0, (g_d && dwe) ? dbe : 4'b0000});
    if (g_if) check("mem_addr_if", {20'b0, mem_addr}, wi);
    if (g_d) begin
      check("mem_addr_d", {20'b0, mem_addr}, wd);
      check("mem_wdata",  mem_wdata, dwd);
    end

    m_rdata    = m_mem[g_if ? wi : wd];
    m_if_valid = rst_n && g_if;
    m_d_valid  = rst_n && g_d && !dwe;
    if (g_d && dwe)
      for (int b = 0; b < 4; b++)
        if (dbe[b]) m_mem[wd][8*b +: 8] = dwd[8*b +: 8];
    if (!rst_n || !ifr || g_if) m_starve = 0;
    else if (g_d && m_starve < STARVE_MAX) m_starve++;
  endtask

  task automatic idle(input logic rst_n);
    step(rst_n, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ra, rd;
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0;
    d_be = 4'h0; d_addr = 32'h40; d_wdata = 32'h0;
    for (int i = 0; i < 4096; i++) m_mem[i] = init_word(i);
    m_starve = 0; m_if_valid = 1'b0; m_d_valid = 1'b0; m_rdata = 32'h0;

    // Reset held two cycles with both sides requesting
    @(negedge clk);
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    check("t1_if_valid", {31'b0, if_valid}, 32'd0);
    check("t1_d_valid",  {31'b0, d_valid},  32'd0);
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h44, 32'h0);
    check("t1_mem_addr", {20'b0, mem_addr}, 32'd17);
    check("t1_d_stall",  {31'b0, d_stall},  32'd0);

    // Fetch only
    idle(1'b1);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t2_mem_addr", {20'b0, mem_addr}, 32'd4);
    check("t2_if_stall", {31'b0, if_stall}, 32'd0);
    idle(1'b1);
    check("t2_if_valid", {31'b0, if_valid}, 32'd1);
    check("t2_if_rdata", if_rdata, 32'h00A00093);

    // Conflict: data first, then fetch once data drops
    step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    check("t3_if_stall", {31'b0, if_stall}, 32'd1);
    check("t3_d_stall",  {31'b0, d_stall},  32'd0);
    step(1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("t3_d_valid",  {31'b0, d_valid},  32'd1);
    check("t3_if_valid", {31'b0, if_valid}, 32'd0);
    check("t3_if_grant", {31'b0, if_stall}, 32'd0);

    // Starvation: D,D,D,D,IF,D
    idle(1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 4'h0, 32'h40 + 32'(4*i), 32'h0);
      check("t4_if_stall", {31'b0, if_stall}, (i == 4) ? 32'd0 : 32'd1);
    end

    // Store one byte lane, then read it back
    idle(1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'b0010, 32'h80, 32'hAABBCCDD);
    idle(1'b1);
    check("t5_store_no_valid", {31'b0, d_valid}, 32'd0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h80, 32'h0);
    idle(1'b1);
    check("t5_d_valid", {31'b0, d_valid}, 32'd1);
    check("t5_d_rdata", d_rdata, 32'h1122CC44);

    // Load issued while reset is asserted never validates
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h84, 32'h0);
    idle(1'b1);
    check("t6_d_valid", {31'b0, d_valid}, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      ra = $urandom; ra[13:2] = 12'($urandom_range(0, 31));
      rd = $urandom; rd[13:2] = 12'($urandom_range(0, 31));
      step($urandom_range(0, 49) != 0,
           $urandom_range(0, 9) < 6, ra,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
           4'($urandom), rd, $urandom);
    end
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
